dl_mux32_rr_arb: RTL and testbench
==================================

Name: dl_mux32_rr_arb

Overview:
- Round-robin arbiter and sequencer for a dl_mux32 datapath: up to 32 requesters share one NUM_BITS-wide output path.
- Picks one requester, drives the mux select from a register, and holds it stable through a valid/ready handshake with the downstream consumer.
- Pulses a per-requester acknowledge on each completed transfer.
- Sits between requester blocks and the dl_mux32 sel input.

Parameters:
- NUM_REQ, 32, number of requesters; must equal the mux input count; range 2..32.
- SEL_WIDTH, $clog2(NUM_REQ), width of the mux select.
- MAX_BURST, 4, maximum consecutive transfers per grant; used only when DL_ARB_BURST_EN is defined; range 1..16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NUM_REQ  per-requester request; bit i drives dl_mux32 in<i>.
- sel  output  SEL_WIDTH  registered mux select, to dl_mux32 sel.
- gnt  output  NUM_REQ  one-hot current owner, all-zero when idle.
- ack  output  NUM_REQ  one-hot single-cycle pulse on a completed transfer.
- out_vld  output  1  mux output is valid for the consumer.
- out_rdy  input  1  consumer accepts the data.

Behaviour:
- Reset (asynchronous assert, synchronous-release use assumed upstream):
  - sel=0, gnt=0, ack=0, out_vld=0.
  - Round-robin pointer ptr=0; state IDLE; burst count=0.
- State IDLE:
  - If any req bit is set, pick the first set bit scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - Register the winner into sel and gnt; set out_vld=1; go to GRANT.
  - Latency from req rising to out_vld is 1 cycle.
  - If no req bit is set, all outputs stay 0 and sel holds its last value.
- State GRANT:
  - sel and gnt are stable while out_vld=1 and out_rdy=0. A grant is never revoked by other requests.
  - Transfer occurs on out_vld && out_rdy:
    - ack[sel] pulses in the next cycle.
    - ptr <= sel+1, wrapping from NUM_REQ-1 to 0.
  - Re-arbitration on the same edge, using the updated ptr and the current req:
    - If a winner exists, load it and keep out_vld=1. Back-to-back transfers have zero bubble.
    - Otherwise go to IDLE with out_vld=0 and gnt=0.
  - Owner withdrawal: if req[sel] drops while in GRANT with no transfer, go to IDLE, clear out_vld and gnt, and leave ptr unchanged.
    - The consumer never sees a transfer from a withdrawn requester.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transfers.
- Simultaneous events:
  - A transfer and the owner dropping req in the same cycle counts as a completed transfer (ack issued).
  - A new req arriving in the same cycle as a transfer participates in re-arbitration.
- Reset mid-transfer: all outputs clear immediately; no ack is issued.
- NUM_REQ not a power of two: sel values of NUM_REQ and above are never produced.
- Requester obligation: hold req until ack or until it deliberately withdraws. Each requester drives its mux input stable while gnt[i]=1.

Optional Feature:
- Macro: DL_ARB_BURST_EN.
- When defined:
  - A burst counter lets the owner keep the grant for up to MAX_BURST consecutive transfers while req[sel] stays high.
  - The count increments on each transfer.
  - When the count reaches MAX_BURST, or req[sel] drops, the arbiter re-arbitrates normally and resets the count to 0.
  - ptr advances only when ownership changes.
  - ack pulses on every transfer.
- When not defined: exactly one transfer per grant, as described above. MAX_BURST is ignored and no counter logic exists.

Test Plan:
- Reset with req=32'hFFFF_FFFF, then release rst, out_rdy=1 -> sel sequence 0,1,2,...,31,0, one per cycle; ack is one-hot matching the previous sel; out_vld is continuous.
- req=32'h0000_0011, out_rdy=0 for 5 cycles, then 1 -> sel=0 held for all 5 cycles, gnt=32'h1; after the transfer, sel=4 and ack=32'h1.
- ptr=5 after a transfer from requester 4, then req=32'h0000_0009 -> winner is 0 (wrap scan 5..31,0), not 3.
- Grant held to requester 7 with out_rdy=0, then req[7] drops -> next cycle out_vld=0, gnt=0, no ack; ptr is unchanged (next winner among {7,8} with both requesting is 7).
- rst asserted asynchronously mid-cycle while out_vld=1 -> out_vld, gnt and ack go to 0 before the next clock edge.
- DL_ARB_BURST_EN, MAX_BURST=4, req=32'h0000_0006, out_rdy=1 -> sel stays 1 for 4 transfers, then 2 for 4 transfers, then 1; ack pulses every cycle.

Source files
------------

// File: rtl/dl_mux32_rr_arb.sv
// Round-robin arbiter/sequencer driving a registered dl_mux32 select with a valid/ready handshake.
// Define DL_ARB_BURST_EN to let an owner keep the grant for up to MAX_BURST transfers.
module dl_mux32_rr_arb #(
    parameter int unsigned NUM_REQ   = 32,
    parameter int unsigned SEL_WIDTH = $clog2(NUM_REQ),
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 out_vld,
    input  logic                 out_rdy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_t;

    state_t               state;
    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] nxt_ptr;
    logic [SEL_WIDTH-1:0] win_idle;
    logic [SEL_WIDTH-1:0] win_xfer;
    logic                 found_idle;
    logic                 found_xfer;
    logic                 xfer;
    logic                 owner_req;
    logic                 keep;

`ifdef DL_ARB_BURST_EN
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);
    logic [CntW-1:0] cnt;
`else
    logic unused_burst;
    assign unused_burst = ^MAX_BURST;
`endif

    // First set bit at or after p, wrapping; msb of the result flags a hit.
    function automatic logic [SEL_WIDTH:0] pick(input logic [NUM_REQ-1:0] r,
                                                input logic [SEL_WIDTH-1:0] p);
        logic [SEL_WIDTH-1:0] k;
        int idx;
        pick = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            idx = int'(p) + i;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            k = SEL_WIDTH'(idx);
            if (r[k]) pick = {1'b1, k};
        end
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_WIDTH-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    always_comb begin
        nxt_ptr = '0;
        if (sel != SEL_WIDTH'(NUM_REQ - 1)) nxt_ptr = sel + 1'b1;
        {found_idle, win_idle} = pick(req, ptr);
        {found_xfer, win_xfer} = pick(req, nxt_ptr);
        xfer      = out_vld & out_rdy;
        owner_req = req[sel];
`ifdef DL_ARB_BURST_EN
        keep = owner_req && (cnt != BurstLast);
`else
        keep = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            sel     <= '0;
            gnt     <= '0;
            ack     <= '0;
            out_vld <= 1'b0;
            ptr     <= '0;
`ifdef DL_ARB_BURST_EN
            cnt     <= '0;
`endif
        end else begin
            ack <= '0;
            unique case (state)
                StIdle: begin
                    if (found_idle) begin
                        sel     <= win_idle;
                        gnt     <= onehot(win_idle);
                        out_vld <= 1'b1;
                        state   <= StGrant;
                    end
                end
                StGrant: begin
                    if (xfer) begin
                        ack <= gnt;
                        if (keep) begin
`ifdef DL_ARB_BURST_EN
                            cnt <= cnt + 1'b1;
`endif
                        end else begin
`ifdef DL_ARB_BURST_EN
                            cnt <= '0;
`endif
                            ptr <= nxt_ptr;
                            // Re-arbitrate on the same edge so back-to-back grants have no bubble.
                            if (found_xfer) begin
                                sel <= win_xfer;
                                gnt <= onehot(win_xfer);
                            end else begin
                                gnt     <= '0;
                                out_vld <= 1'b0;
                                state   <= StIdle;
                            end
                        end
                    end else if (!owner_req) begin
                        gnt     <= '0;
                        out_vld <= 1'b0;
                        state   <= StIdle;
`ifdef DL_ARB_BURST_EN
                        cnt     <= '0;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dl_mux32_rr_arb.sv
// Self-checking bench for dl_mux32_rr_arb: directed scenarios plus randomized traffic
// compared against an owner/pointer reference model.
module tb_dl_mux32_rr_arb;

    localparam int N  = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [4:0]    sel;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          out_vld;
    logic          out_rdy;

    int total = 0;
    int bad   = 0;

    // Reference model state: owner -1 means no grant outstanding.
    int m_ptr, m_owner, m_sel, m_ack, m_cnt;

    dl_mux32_rr_arb #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .sel     (sel),
        .gnt     (gnt),
        .ack     (ack),
        .out_vld (out_vld),
        .out_rdy (out_rdy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int scan(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] bit_of(input int i);
        logic [31:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_sel = 0; m_ack = -1; m_cnt = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic rdy);
        int w;
        bit burst_on;
`ifdef DL_ARB_BURST_EN
        burst_on = 1'b1;
`else
        burst_on = 1'b0;
`endif
        m_ack = -1;
        if (m_owner < 0) begin
            w = scan(r, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_cnt = 0;
            end
        end else if (rdy) begin
            m_ack = m_owner;
            if (burst_on && r[m_owner] && (m_cnt + 1 < MB)) begin
                m_cnt++;
            end else begin
                m_cnt   = 0;
                m_ptr   = (m_owner + 1) % N;
                w       = scan(r, m_ptr);
                m_owner = w;
                if (w >= 0) m_sel = w;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1; m_cnt = 0;
        end
    endtask

    task automatic check_all();
        check_eq("sel", 32'(sel), 32'(m_sel));
        check_eq("gnt", gnt, bit_of(m_owner));
        check_eq("ack", ack, bit_of(m_ack));
        check_eq("out_vld", 32'(out_vld), 32'(m_owner >= 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(req, out_rdy);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_vld", 32'(out_vld), 32'd0);
        check_eq("rst_gnt", gnt, 32'd0);
        check_eq("rst_ack", ack, 32'd0);
        check_eq("rst_sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        req = '0; out_rdy = 1'b0; rst = 1'b0;
        #2;

        // Full request set, consumer always ready: sel walks 0..31 then wraps.
        req = '1; out_rdy = 1'b1;
        do_reset();
        for (int i = 0; i < 33; i++) begin
            tick();
            check_eq("walk_sel", 32'(sel), 32'(i % N));
            if (i > 0) check_eq("walk_ack", ack, bit_of((i - 1) % N));
        end

        // Asynchronous reset while a transfer is in flight.
        rst = 1'b1;
        #1;
        check_eq("async_vld", 32'(out_vld), 32'd0);
        check_eq("async_gnt", gnt, 32'd0);
        check_eq("async_ack", ack, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Hold with consumer stalled, then transfer and wrap scan from ptr=5.
        do_reset();
        req = 32'h0000_0011; out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_sel", 32'(sel), 32'd0);
            check_eq("hold_gnt", gnt, 32'h1);
        end
        out_rdy = 1'b1;
        tick();
        check_eq("after_sel", 32'(sel), 32'd4);
        check_eq("after_ack", ack, 32'h1);
        req = 32'h0000_0009;
        tick();
        check_eq("wrap_sel", 32'(sel), 32'd0);
        check_eq("wrap_ack", ack, 32'h10);

        // Owner withdrawal: no ack, grant dropped, pointer untouched.
        do_reset();
        req = 32'h0000_0080; out_rdy = 1'b0;
        tick();
        check_eq("wd_sel", 32'(sel), 32'd7);
        req = 32'h0000_0100;
        tick();
        check_eq("wd_vld", 32'(out_vld), 32'd0);
        check_eq("wd_gnt", gnt, 32'd0);
        check_eq("wd_ack", ack, 32'd0);
        req = 32'h0000_0180;
        tick();
        check_eq("wd_next", 32'(sel), 32'd7);

`ifdef DL_ARB_BURST_EN
        do_reset();
        req = 32'h0000_0006; out_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq("burst_sel", 32'(sel), (i >= 4 && i < 8) ? 32'd2 : 32'd1);
        end
`endif

        // Randomized traffic with withdrawals, stalls and late arrivals.
        do_reset();
        req = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = $urandom & $urandom & $urandom;
            else req[$urandom_range(0, N - 1)] = ~req[$urandom_range(0, N - 1)] | req[0];
            if ($urandom_range(0, 15) == 0) req = '0;
            out_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
